// File: rtl/switch_arb_pkg.sv
// Shared types and constants for the switch output-port drain arbiter.
package switch_arb_pkg;

  localparam int NUM_PORTS = 4;
  localparam int HDR_BYTES = 3;

  typedef logic [1:0] port_t;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WLEN,
    BODY,
    DRAIN
  } arb_state_t;

  // First requesting port after rr, wrapping; rr itself has lowest priority.
  function automatic port_t rr_pick(input port_t rr, input logic [NUM_PORTS-1:0] req);
    port_t idx;
    rr_pick = rr;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      idx = rr + port_t'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered head entry and occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // NOTE: storage is deliberately not reset; pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/switch_port_drain_arbiter.sv
// Round-robin drain of four switch output ports into one buffered byte stream,
// following each packet's length byte to find its end.
module switch_port_drain_arbiter
  import switch_arb_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          ready,
  input  logic [NUM_PORTS*DATA_W-1:0]   port_data,
  output logic [NUM_PORTS-1:0]          read,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic [1:0]                    out_port,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          abort
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    port_t             port;
    logic              last;
  } fifo_entry_t;

  arb_state_t  state;
  port_t       grant;
  port_t       rr;
  logic        inflight;
  logic        inflight_last;
  logic [1:0]  hdr_cnt;
  logic [8:0]  remaining;
  logic [TW-1:0] tmo_cnt;

  logic [DATA_W-1:0] grant_data;
  logic [7:0]        len_byte;
  logic              grant_ready;
  logic [CW:0]       occupancy;
  logic              room;
  logic              issue;
  logic              issue_last;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  fifo_entry_t   push_entry;
  fifo_entry_t   head_entry;

  assign grant_data  = port_data[grant*DATA_W +: DATA_W];
  assign len_byte    = grant_data[7:0];
  assign grant_ready = ready[grant];

  // A read issued now lands in the FIFO next cycle, so count the one already in flight.
  assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign room       = (occupancy < (CW+1)'(FIFO_DEPTH));
  assign issue      = ((state == HDR) || (state == BODY)) && grant_ready && room;
  assign issue_last = (state == BODY) && (remaining == 9'd1);

  assign read = issue ? (4'b0001 << grant) : '0;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      grant         <= '0;
      rr            <= 2'd3;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      hdr_cnt       <= '0;
      remaining     <= '0;
      tmo_cnt       <= '0;
      abort         <= 1'b0;
    end else begin
      abort         <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && issue_last;
      case (state)
        IDLE: begin
          if (|ready) begin
            grant   <= rr_pick(rr, ready);
            hdr_cnt <= '0;
            tmo_cnt <= '0;
            state   <= HDR;
          end
        end
        HDR, BODY: begin
          if (issue) begin
            if (state == HDR) begin
              hdr_cnt <= hdr_cnt + 2'd1;
              if (hdr_cnt == 2'(HDR_BYTES - 1)) state <= WLEN;
            end else begin
              remaining <= remaining - 9'd1;
              if (issue_last) state <= DRAIN;
            end
          end
          // Backpressure from our own FIFO does not count towards the timeout.
          if (grant_ready) begin
            tmo_cnt <= '0;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            tmo_cnt <= '0;
            abort   <= 1'b1;
            rr      <= grant;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        WLEN: begin
          remaining <= {1'b0, len_byte} + 9'd1;
          tmo_cnt   <= '0;
          state     <= BODY;
        end
        DRAIN: begin
          rr    <= grant;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign push_entry = '{data: grant_data, port: grant, last: inflight_last};

  sync_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (push_entry),
    .pop       (out_valid & out_ready),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = head_entry.data;
  assign out_port  = head_entry.port;
  assign out_last  = head_entry.last;

  no_push_when_full: assert property (@(posedge clk) disable iff (!reset) !(inflight && fifo_full));

endmodule

// File: tb/tb_switch_port_drain_arbiter.sv
// Scoreboard bench: a switch model serves read handshakes; expected bytes are queued at load time.
module tb_switch_port_drain_arbiter;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [3:0]           ready;
  logic [4*DATA_W-1:0]  port_data;
  logic [3:0]           read;
  logic                 out_valid;
  logic [DATA_W-1:0]    out_data;
  logic [1:0]           out_port;
  logic                 out_last;
  logic                 out_ready;
  logic                 busy;
  logic                 abort;

  switch_port_drain_arbiter #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ready     (ready),
    .port_data (port_data),
    .read      (read),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_port  (out_port),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .abort     (abort)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0]  pq [4][$];
  int          rd_cnt [4];
  int          drop_at [4];
  logic [3:0]  rd_seen = '0;
  int          cyc = 0;
  int          rd_log [$];
  logic [31:0] sb [$];
  int          n_abort = 0;
  int          n_pops = 0;
  int          tot_reads = 0;
  bit          chk_out = 1'b0;

  // Switch model: a read seen in cycle t puts the next byte on the port early in cycle t+1.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (reset) begin
      for (int n = 0; n < 4; n++) begin
        if (rd_seen[n]) begin
          if (pq[n].size() > 0) begin
            port_data[n*DATA_W +: DATA_W] = pq[n].pop_front();
            rd_cnt[n]++;
          end else begin
            check($sformatf("read_port%0d_without_data", n), 1, 0);
          end
        end
      end
    end
    for (int n = 0; n < 4; n++)
      ready[n] = (pq[n].size() > 0) && (rd_cnt[n] < drop_at[n]);
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    rd_seen = read;
    if (reset) begin
      if (read != '0) begin
        rd_log.push_back(cyc);
        tot_reads += $countones(read);
      end
      check("read_onehot", {31'd0, $countones(read) <= 1}, 1);
      if (chk_out) check("outstanding_reads", {31'd0, (tot_reads - n_pops) <= FIFO_DEPTH}, 1);
      if (abort) n_abort++;
      if (out_valid && out_ready) begin
        n_pops++;
        if (sb.size() == 0) check("unexpected_byte", {21'd0, out_port, out_last, out_data}, 32'hFFFF_FFFF);
        else                check("out_byte", {21'd0, out_port, out_last, out_data}, sb.pop_front());
      end
    end
  end

  // Packet: DA, SA, LEN, LEN payload bytes, parity; only the first n_exp bytes are expected out.
  task automatic load_pkt(input int p, input int len, input logic [7:0] base, input int n_exp);
    logic [7:0] b;
    logic [7:0] par;
    int total;
    total = len + 4;
    par = '0;
    for (int i = 0; i < total; i++) begin
      if (i == 0)              b = 8'hAA;
      else if (i == 1)         b = 8'h55;
      else if (i == 2)         b = 8'(len);
      else if (i < total - 1)  b = base + 8'(i - 2);
      else                     b = par;
      par ^= b;
      pq[p].push_back(b);
      if (i < n_exp) sb.push_back({21'd0, 2'(p), (i == total - 1), b});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic flush_model();
    for (int n = 0; n < 4; n++) begin
      pq[n].delete();
      drop_at[n] = 1 << 30;
    end
    sb.delete();
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    flush_model();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !busy && !out_valid) done = 1'b1;
    end
    check(tag, {31'd0, done}, 1);
  endtask

  initial begin
    int  r0;
    int  p0;
    int  a0;
    bit  found;
    reset     = 1'b0;
    ready     = '0;
    port_data = '0;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      drop_at[n] = 1 << 30;
      rd_cnt[n]  = 0;
    end
    #1;
    check("rst_read", {28'd0, read}, 0);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_last", {31'd0, out_last}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_abort", {31'd0, abort}, 0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;

    // Single LEN=3 packet on port 2.
    tick();
    rd_log.delete();
    load_pkt(2, 3, 8'h00, 7);
    wait_done("t1_done", 100);
    check("t1_read_count", rd_log.size(), 7);
    for (int i = 1; i < rd_log.size() && i < 7; i++)
      check($sformatf("t1_read_gap%0d", i), rd_log[i] - rd_log[i-1], (i == 3) ? 2 : 1);

    // All four ports at once after reset, then ports 1 and 3.
    do_reset();
    load_pkt(0, 1, 8'h10, 5);
    load_pkt(1, 1, 8'h20, 5);
    load_pkt(2, 1, 8'h30, 5);
    load_pkt(3, 1, 8'h40, 5);
    wait_done("t2_round1", 200);
    tick();
    load_pkt(1, 1, 8'h50, 5);
    load_pkt(3, 1, 8'h60, 5);
    wait_done("t2_round2", 200);

    // LEN=0 packet on port 0.
    tick();
    r0 = rd_cnt[0];
    p0 = n_pops;
    load_pkt(0, 0, 8'h00, 4);
    wait_done("t3_done", 100);
    check("t3_reads", rd_cnt[0] - r0, 4);
    check("t3_bytes", n_pops - p0, 4);

    // Downstream stall during a LEN=10 packet on port 3.
    tick();
    out_ready = 1'b0;
    chk_out   = 1'b1;
    r0 = rd_cnt[3];
    load_pkt(3, 10, 8'h70, 14);
    repeat (20) @(posedge clk);
    #2;
    check("t4_stalled_reads", rd_cnt[3] - r0, FIFO_DEPTH);
    out_ready = 1'b1;
    wait_done("t4_done", 200);
    chk_out = 1'b0;

    // Port 1 stops after five bytes; port 2 waits behind it.
    tick();
    a0 = n_abort;
    drop_at[1] = rd_cnt[1] + 5;
    load_pkt(1, 10, 8'h80, 5);
    load_pkt(2, 2, 8'h90, 6);
    for (int i = 0; i < 100 && n_abort == a0; i++) @(negedge clk);
    #1;
    check("t5_abort_seen", n_abort - a0, 1);
    pq[1].delete();
    drop_at[1] = 1 << 30;
    wait_done("t5_done", 200);
    check("t5_abort_count", n_abort - a0, 1);

    // Asynchronous reset while a BODY read is on the wire.
    tick();
    out_ready = 1'b0;
    r0 = rd_cnt[2];
    load_pkt(2, 10, 8'hA0, 0);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (read[2] && (rd_cnt[2] - r0 == 3)) found = 1'b1;
    end
    check("t6_reached_body", {31'd0, found}, 1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_read", {28'd0, read}, 0);
    check("t6_rst_out_valid", {31'd0, out_valid}, 0);
    check("t6_rst_busy", {31'd0, busy}, 0);
    flush_model();
    repeat (2) @(posedge clk);
    #2;
    reset     = 1'b1;
    out_ready = 1'b1;
    load_pkt(0, 1, 8'hB0, 5);
    load_pkt(3, 1, 8'hC0, 5);
    wait_done("t6_after_reset", 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
